// File: rtl/delay_feed.sv
// delay_feed: write-side feeder for the 32-slot DELAY channel-state shift register.
//
// The DELAY block is a plain shift register. This module keeps a slot counter
// aligned with the channel that DELAY is presenting on Y_in, and drives X every
// cycle:
//   - by default it recirculates Y_in, so every channel keeps its state;
//   - when a held update's channel comes round, it writes the update instead;
//   - during a clear sweep, or in reset, it writes RSTVAL.
// Updates arrive from the shared datapath through a one-entry hold register
// with a valid/ready handshake.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   scan_in0..4, scan_enable,
//   test_mode                   DFT hooks, functionally unused
//   scan_out0..4                DFT scan outputs, tied to 0
//   fs                          frame sync, realigns slot to 0 on the next cycle
//   Y_in                        DELAY output for the current slot's channel
//   X                           DELAY input
//   slot                        current channel slot
//   upd_valid/upd_chan/upd_data update request from the datapath
//   upd_ready                   update accepted when upd_valid && upd_ready
//   clr_req                     start a full clear sweep
//   clr_busy                    clear sweep in progress
//   wr_pulse/wr_chan            held update written into X this cycle, and its channel
module delay_feed #(
    parameter int              SIZE   = 16,
    parameter logic [SIZE-1:0] RSTVAL = '0,
    parameter int              NCHAN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scan_in0,
    input  logic            scan_in1,
    input  logic            scan_in2,
    input  logic            scan_in3,
    input  logic            scan_in4,
    input  logic            scan_enable,
    input  logic            test_mode,
    output logic            scan_out0,
    output logic            scan_out1,
    output logic            scan_out2,
    output logic            scan_out3,
    output logic            scan_out4,
    input  logic            fs,
    input  logic [SIZE-1:0] Y_in,
    output logic [SIZE-1:0] X,
    output logic [4:0]      slot,
    input  logic            upd_valid,
    input  logic [4:0]      upd_chan,
    input  logic [SIZE-1:0] upd_data,
    output logic            upd_ready,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            wr_pulse,
    output logic [4:0]      wr_chan
);

    localparam logic [4:0] LAST_SLOT = 5'(NCHAN - 1);

    logic [4:0]      slot_q;
    logic            hold_valid_q;
    logic [4:0]      hold_chan_q;
    logic [SIZE-1:0] hold_data_q;
    logic            clr_busy_q;
    logic [4:0]      clr_cnt_q;

    logic            write_now;
    logic            accept;
    logic            unused_dft;

    // Scan hooks are stitched in at DFT insertion; the RTL only ties them off.
    assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                          scan_enable, test_mode};
    assign scan_out0  = 1'b0;
    assign scan_out1  = 1'b0;
    assign scan_out2  = 1'b0;
    assign scan_out3  = 1'b0;
    assign scan_out4  = 1'b0;

    // The held entry is written only on its own slot and never during a clear
    // sweep; a sweep simply defers it until the slot comes round again.
    assign write_now = hold_valid_q && (hold_chan_q == slot_q) && !clr_busy_q;
    // The hold register can take a new entry in the same cycle its old entry
    // leaves for X.
    assign upd_ready = !reset && (!hold_valid_q || write_now);
    assign accept    = upd_valid && upd_ready;

    assign slot      = slot_q;
    assign clr_busy  = clr_busy_q;
    assign wr_pulse  = write_now && !reset;
    assign wr_chan   = hold_chan_q;

    always_comb begin
        X = Y_in;
        if (reset || clr_busy_q) begin
            X = RSTVAL;
        end else if (write_now) begin
            X = hold_data_q;
        end
    end

    // Control state: slot counter, hold-valid flag, clear sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q       <= '0;
            hold_valid_q <= 1'b0;
            clr_busy_q   <= 1'b0;
            clr_cnt_q    <= '0;
        end else begin
            if (fs || slot_q == LAST_SLOT) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_q + 5'd1;
            end

            if (accept) begin
                hold_valid_q <= 1'b1;
            end else if (write_now) begin
                hold_valid_q <= 1'b0;
            end

            // The sweep counts its own cycles rather than slots, so an fs
            // mid-sweep cannot shorten or lengthen it: exactly NCHAN cycles
            // of RSTVAL go into DELAY.
            if (!clr_busy_q) begin
                if (clr_req) begin
                    clr_busy_q <= 1'b1;
                    clr_cnt_q  <= '0;
                end
            end else begin
                clr_cnt_q <= clr_cnt_q + 5'd1;
                if (clr_cnt_q == LAST_SLOT) begin
                    clr_busy_q <= 1'b0;
                end
            end
        end
    end

    // Hold payload carries no reset; it is qualified by hold_valid_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_chan_q <= upd_chan;
            hold_data_q <= upd_data;
        end
    end

endmodule
